// File: rtl/spi_pkg.sv
// Shared SPI types and constants for the transfer arbiter: FSM states,
// transfer sizes, read-data mask helper and the default watchdog limit.
package spi_pkg;

  localparam int AWIDTH = 24;
  localparam int DWIDTH = 32;
  localparam int ARB_TIMEOUT_DEFAULT = 1024;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    RESP  = 3'd4
  } arb_state_t;

  // SZ_ILL names the reserved encoding so every 2-bit value casts cleanly.
  typedef enum logic [1:0] {
    SZ8    = 2'b00,
    SZ16   = 2'b01,
    SZ32   = 2'b10,
    SZ_ILL = 2'b11
  } xfer_size_t;

  function automatic logic [DWIDTH-1:0] size_mask(input xfer_size_t sz);
    case (sz)
      SZ8:     size_mask = {{(DWIDTH-8){1'b0}}, 8'hFF};
      SZ16:    size_mask = {{(DWIDTH-16){1'b0}}, 16'hFFFF};
      SZ32:    size_mask = '1;
      default: size_mask = '0;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first valid requester after 'last',
// wrapping around; returns one-hot grant, its index and an any-valid flag.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] cand;

  // Scan offsets from farthest to nearest so the nearest valid one wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int off = N; off >= 1; off--) begin
      cand = IW'((int'(last) + off) % N);
      if (valid[cand]) begin
        grant       = '0;
        grant[cand] = 1'b1;
        idx         = cand;
        any         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_xfer_arbiter.sv
// Shares one SPI master between NUM_REQ requesters with round-robin grants,
// command legality checks and response return. Define SPI_ARB_TIMEOUT_EN for the watchdog.
module spi_xfer_arbiter
  import spi_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int AWIDTH      = spi_pkg::AWIDTH,
  parameter int DWIDTH      = spi_pkg::DWIDTH,
  parameter int TIMEOUT_CYC = spi_pkg::ARB_TIMEOUT_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ-1:0]          req_write,
  input  logic [NUM_REQ*2-1:0]        req_size,
  input  logic [NUM_REQ*AWIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*DWIDTH-1:0]   req_wdata,
  input  logic [NUM_REQ*2-1:0]        req_mode,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic                        rsp_err,
  output logic [DWIDTH-1:0]           rsp_rdata,
  output logic                        m_start,
  output logic                        m_write,
  output logic [1:0]                  m_size,
  output logic [AWIDTH-1:0]           m_addr,
  output logic [DWIDTH-1:0]           m_wdata,
  output logic [1:0]                  m_mode,
  input  logic                        m_busy,
  input  logic                        m_done,
  input  logic [DWIDTH-1:0]           m_rdata
);

  localparam int IW = $clog2(NUM_REQ);

  arb_state_t          state_q, state_d;
  logic [IW-1:0]       last_grant_q, last_grant_d;
  logic [IW-1:0]       gidx_q, gidx_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic                write_q, write_d;
  logic [1:0]          size_q, size_d;
  logic [AWIDTH-1:0]   addr_q, addr_d;
  logic [DWIDTH-1:0]   wdata_q, wdata_d;
  logic [1:0]          mode_q, mode_d;
  logic                rsp_err_q, rsp_err_d;
  logic [DWIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;

  logic [NUM_REQ-1:0]  req_ready_c, rsp_valid_c;
  logic                m_start_c;
  logic                illegal;
  logic                timeout_hit;
  logic [DWIDTH-1:0]   rdata_masked;

  logic [NUM_REQ-1:0]  arb_grant;
  logic [IW-1:0]       arb_idx;
  logic                arb_any;

  logic [1:0]          size_arr  [NUM_REQ];
  logic [AWIDTH-1:0]   addr_arr  [NUM_REQ];
  logic [DWIDTH-1:0]   wdata_arr [NUM_REQ];
  logic [1:0]          mode_arr  [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign size_arr[gi]  = req_size[gi*2 +: 2];
    assign addr_arr[gi]  = req_addr[gi*AWIDTH +: AWIDTH];
    assign wdata_arr[gi] = req_wdata[gi*DWIDTH +: DWIDTH];
    assign mode_arr[gi]  = req_mode[gi*2 +: 2];
  end

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
    .valid (req_valid),
    .last  (last_grant_q),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  always_comb begin
    case (xfer_size_t'(size_q))
      SZ16:    illegal = addr_q[0];
      SZ32:    illegal = |addr_q[1:0];
      SZ_ILL:  illegal = 1'b1;
      default: illegal = 1'b0;
    endcase
  end

  assign rdata_masked = m_rdata & DWIDTH'(size_mask(xfer_size_t'(size_q)));

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;
  logic [TW-1:0] timer_q, timer_d;

  always_comb begin
    timer_d = timer_q;
    if (state_q == CHECK) begin
      timer_d = '0;
    end else if (state_q == ISSUE || state_q == WAIT) begin
      timer_d = timer_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) timer_q <= '0;
    else        timer_q <= timer_d;
  end

  assign timeout_hit = (state_q == ISSUE || state_q == WAIT) &&
                       (timer_q == TW'(TIMEOUT_CYC - 1));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYC > 0);
  assign timeout_hit    = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gidx_d       = gidx_q;
    grant_d      = grant_q;
    write_d      = write_q;
    size_d       = size_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    mode_d       = mode_q;
    rsp_err_d    = rsp_err_q;
    rsp_rdata_d  = rsp_rdata_q;
    req_ready_c  = '0;
    rsp_valid_c  = '0;
    m_start_c    = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          req_ready_c = arb_grant;
          grant_d     = arb_grant;
          gidx_d      = arb_idx;
          write_d     = req_write[arb_idx];
          size_d      = size_arr[arb_idx];
          addr_d      = addr_arr[arb_idx];
          wdata_d     = wdata_arr[arb_idx];
          mode_d      = mode_arr[arb_idx];
          state_d     = CHECK;
        end
      end
      CHECK: begin
        if (illegal) begin
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          state_d     = RESP;
        end else begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (timeout_hit) begin
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          state_d     = RESP;
        end else if (!m_busy) begin
          m_start_c = 1'b1;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        // The watchdog wins over an m_done arriving in the same cycle.
        if (timeout_hit) begin
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          state_d     = RESP;
        end else if (m_done) begin
          rsp_err_d   = 1'b0;
          rsp_rdata_d = write_q ? '0 : rdata_masked;
          state_d     = RESP;
        end
      end
      RESP: begin
        rsp_valid_c  = grant_q;
        last_grant_d = gidx_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= IW'(NUM_REQ - 1);
      gidx_q       <= '0;
      grant_q      <= '0;
      write_q      <= 1'b0;
      size_q       <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      mode_q       <= '0;
      rsp_err_q    <= 1'b0;
      rsp_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gidx_q       <= gidx_d;
      grant_q      <= grant_d;
      write_q      <= write_d;
      size_q       <= size_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      mode_q       <= mode_d;
      rsp_err_q    <= rsp_err_d;
      rsp_rdata_q  <= rsp_rdata_d;
    end
  end

  // req_ready is combinational from req_valid, so mask it while reset is held.
  assign req_ready = req_ready_c & {NUM_REQ{rst_n}};
  assign rsp_valid = rsp_valid_c;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign m_start   = m_start_c;
  assign m_write   = write_q;
  assign m_size    = size_q;
  assign m_addr    = addr_q;
  assign m_wdata   = wdata_q;
  assign m_mode    = mode_q;

endmodule

// File: doc/spi_xfer_arbiter.md
Name: spi_xfer_arbiter

Overview:
- Shares one SPI master transfer engine between NUM_REQ local requesters using round-robin arbitration.
- Accepts one command per grant (write/read, size, address, write data, SPI mode). Checks it for legality, sequences the master's start/done handshake, and returns read data or an error to the granted requester.
- Sits between on-chip clients and the SPI master; the SPI slave memory model is the far end.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- AWIDTH, spi_pkg::AWIDTH, address width.
- DWIDTH, spi_pkg::DWIDTH, data width (32).
- TIMEOUT_CYC, 1024, watchdog limit in clk cycles; used only with SPI_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester command valid
- req_ready  out  NUM_REQ  one-hot; pulses for one cycle when the command is accepted
- req_write  in  NUM_REQ  1 = write, 0 = read
- req_size  in  NUM_REQ*2  00 = 8 b, 01 = 16 b, 10 = 32 b, 11 = illegal
- req_addr  in  NUM_REQ*AWIDTH  byte address
- req_wdata  in  NUM_REQ*DWIDTH  write data, LSB-aligned
- req_mode  in  NUM_REQ*2  {cpol,cpha}
- rsp_valid  out  NUM_REQ  one-hot, one-cycle response pulse
- rsp_err  out  1  qualifies rsp_valid
- rsp_rdata  out  DWIDTH  read data, zero-extended to DWIDTH
- m_start  out  1  one-cycle start pulse to the SPI master
- m_write, m_size, m_addr, m_wdata, m_mode  out  1/2/AWIDTH/DWIDTH/2  latched command to the master
- m_busy  in  1  master transfer in progress
- m_done  in  1  one-cycle pulse at transfer end
- m_rdata  in  DWIDTH  valid when m_done is high

Behaviour:
- Reset values:
  - All outputs are 0.
  - State is IDLE.
  - last_grant = NUM_REQ-1, so requester 0 has first priority after reset.
- State IDLE:
  - Grant g = first requester with req_valid set, searching from last_grant+1 with wrap-around.
  - If any request is present: req_ready[g]=1 this cycle; latch write, size, addr, wdata and mode of g; go to CHECK.
  - If no request is present: stay in IDLE.
- State CHECK (1 cycle), illegal when any of:
  - size == 11;
  - size == 01 and addr[0] != 0;
  - size == 10 and addr[1:0] != 0.
  - Illegal: set err, go to RESP.
  - Legal: go to ISSUE.
- State ISSUE:
  - m_busy high: wait.
  - m_busy low: m_start=1 for exactly one cycle, go to WAIT.
- State WAIT:
  - m_done is sampled only in this state.
  - On m_done:
    - read: latch m_rdata masked to size (8 b keeps [7:0], 16 b keeps [15:0], 32 b keeps all); upper bits are 0.
    - write: latched data is 0.
  - Then go to RESP.
- State RESP:
  - rsp_valid[g]=1 for one cycle, with rsp_err and rsp_rdata.
  - last_grant <= g; go to IDLE.
- m_* command outputs hold the latched values from CHECK until the end of RESP; they never change while m_busy is high.
- rsp_rdata and rsp_err hold their values until the next RESP.
- Minimum latency, req_ready to rsp_valid: 3 cycles plus the master transfer time. The error path takes exactly 2 cycles (CHECK, RESP) and never asserts m_start.
- Fairness: no requester is granted twice while another has held req_valid continuously.
- Requesters must hold their command stable while req_valid is high and before req_ready. req_valid dropping before grant is legal; that requester is skipped.
- Asynchronous reset mid-transfer returns to IDLE immediately and clears all pulses. The master is responsible for its own abort; a stale m_done seen in IDLE, CHECK or ISSUE is ignored.

Optional Feature:
- Macro SPI_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to ISSUE and increments each cycle in ISSUE or WAIT.
  - Reaching TIMEOUT_CYC-1 forces RESP with rsp_err=1 and rsp_rdata=0; m_done arriving in that same cycle is ignored.
- Undefined: no counter; the block waits indefinitely.

Decomposition:
- spi_pkg gains:
  - typedef arb_state_t {IDLE, CHECK, ISSUE, WAIT, RESP};
  - typedef xfer_size_t with SZ8, SZ16, SZ32;
  - function size_mask(xfer_size_t), returning the rdata mask;
  - constant ARB_TIMEOUT_DEFAULT.
- One sub-module, rr_arbiter: combinational round-robin pick from a valid vector and last_grant. Outputs one-hot grant and index.

Test Plan:
- Single read: req0 read, size 10, addr 0x10, m_rdata=0xDEADBEEF -> one m_start with m_addr=0x10 and m_write=0; rsp_valid[0] with rsp_rdata=0xDEADBEEF, rsp_err=0.
- Byte read masking: size 00, m_rdata=0xDEADBEEF -> rsp_rdata=0x000000EF.
- Round-robin: req0..req3 all valid continuously -> grant order 0,1,2,3,0. After reset, with only req2 and req1 valid -> 1 then 2.
- Illegal commands:
  - size 11 -> rsp_err=1 two cycles after req_ready, no m_start.
  - size 10 with addr 0x02 -> same response.
- m_busy held high for 5 cycles in ISSUE -> m_start is delayed until the first cycle m_busy is low; m_mode equals the granted req_mode throughout.
- Reset asserted in WAIT -> all outputs 0 immediately; a later m_done yields no rsp_valid; the next grant goes to requester 0. With SPI_ARB_TIMEOUT_EN and TIMEOUT_CYC=16, no m_done -> rsp_err=1 after 16 cycles.
